// File: rtl/encap_mem_pkg.sv
// Shared definitions for the encap wide-entry lookup memory.
// Covers the PIO address field offsets, the PIO FSM states and the sizing helpers.
package encap_mem_pkg;

  localparam int unsigned PIO_NBITS    = 64;
  localparam int unsigned LANE_SEL_LSB = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    RD_ACK,
    COMMIT,
    WR_ACK
  } pio_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Never returns less than 1, so single-lane builds still get a valid select field.
  function automatic int unsigned clog2_min1(input int unsigned val);
    int unsigned bits;
    bits = 0;
    for (int unsigned b = 0; b < 32; b++)
      if ((32'd1 << b) < val) bits = b + 1;
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/encap_mem_wide_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// When a read and a write hit the same address in one cycle, the read returns the old data.
module encap_mem_wide_ram #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned DEPTH_NBITS = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_NBITS-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   re,
  input  logic [DEPTH_NBITS-1:0] raddr,
  output logic [WIDTH-1:0]       rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_NBITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/encap_mem_wide.sv
// Wide-entry lookup memory with a PIO management port and NUM_APP application read ports.
// PIO writes are collected lane by lane in a staging buffer and committed atomically.
module encap_mem_wide
  import encap_mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned DEPTH_NBITS = 10,
  parameter int unsigned LANE_NBITS  = 64,
  parameter int unsigned NUM_APP     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PIO_NBITS-1:0]           reg_addr,
  input  logic [PIO_NBITS-1:0]           reg_din,
  input  logic                           reg_rd,
  input  logic                           reg_wr,
  input  logic                           reg_ms,
  output logic                           mem_ack,
  output logic [PIO_NBITS-1:0]           mem_rdata,
  output logic                           partial_commit_err,
  input  logic [NUM_APP-1:0]             app_rd,
  input  logic [NUM_APP*DEPTH_NBITS-1:0] app_raddr,
  output logic [NUM_APP-1:0]             app_ack,
  output logic [NUM_APP*WIDTH-1:0]       app_rdata
);

  localparam int unsigned NUM_LANES      = ceil_div(WIDTH, LANE_NBITS);
  localparam int unsigned LANE_SEL_NBITS = clog2_min1(NUM_LANES);
  localparam int unsigned STAGE_NBITS    = NUM_LANES * LANE_NBITS;
  localparam int unsigned ENTRY_LSB      = LANE_SEL_LSB + LANE_SEL_NBITS;
  localparam logic [LANE_SEL_NBITS-1:0] LAST_LANE = LANE_SEL_NBITS'(NUM_LANES - 1);
  localparam logic [NUM_LANES-1:0]      FULL_MASK = '1;

  pio_state_e                state_q, state_n;
  logic [LANE_SEL_NBITS-1:0] lane_in, rd_lane_q;
  logic [DEPTH_NBITS-1:0]    entry_in, tag_q;
  logic [NUM_LANES-1:0]      mask_q, lane_bit;
  logic [STAGE_NBITS-1:0]    stage_q, pio_ext;
  logic [WIDTH-1:0]          pio_q;
  logic [LANE_NBITS-1:0]     rd_lane_data;
  logic                      lane_ok, wr_acc, rd_acc, commit;
  logic [NUM_APP-1:0]        rd_d1_q;
  logic [WIDTH-1:0]          app_q [NUM_APP];
  logic                      unused_bits;

  assign lane_in     = reg_addr[LANE_SEL_LSB +: LANE_SEL_NBITS];
  assign entry_in    = reg_addr[ENTRY_LSB +: DEPTH_NBITS];
  assign lane_ok     = {1'b0, lane_in} < (LANE_SEL_NBITS + 1)'(NUM_LANES);
  assign lane_bit    = NUM_LANES'(1) << lane_in;
  assign wr_acc      = (state_q == IDLE) && reg_ms && reg_wr;
  assign rd_acc      = (state_q == IDLE) && reg_ms && reg_rd && !reg_wr;
  assign commit      = (state_q == COMMIT);
  assign unused_bits = ^{reg_addr, reg_din, stage_q};

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_acc)      state_n = (lane_in == LAST_LANE) ? COMMIT : WR_ACK;
        else if (rd_acc) state_n = RD_MEM;
      end
      RD_MEM:  state_n = RD_ACK;
      COMMIT:  state_n = WR_ACK;
      default: state_n = IDLE;
    endcase
  end

  // Lanes past NUM_LANES select nothing and read back as zero.
  assign pio_ext = STAGE_NBITS'(pio_q);
  always_comb begin
    rd_lane_data = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++)
      if (rd_lane_q == LANE_SEL_NBITS'(l)) rd_lane_data = pio_ext[l*LANE_NBITS +: LANE_NBITS];
  end

  // mem_ack is registered from the next state, so it is high exactly in RD_ACK/WR_ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      rd_lane_q <= '0;
    end else begin
      state_q <= state_n;
      mem_ack <= (state_n == RD_ACK) || (state_n == WR_ACK);
      if (rd_acc) rd_lane_q <= lane_in;
      if (state_q == RD_MEM) mem_rdata <= PIO_NBITS'(rd_lane_data);
    end
  end

  // A lane write to an entry other than the staged one abandons the staged lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q             <= '0;
      tag_q              <= '0;
      stage_q            <= '0;
      partial_commit_err <= 1'b0;
    end else if (commit) begin
      mask_q <= '0;
      if (mask_q != FULL_MASK) partial_commit_err <= 1'b1;
    end else if (wr_acc && lane_ok) begin
      for (int unsigned l = 0; l < NUM_LANES; l++)
        if (lane_in == LANE_SEL_NBITS'(l)) stage_q[l*LANE_NBITS +: LANE_NBITS] <= reg_din[LANE_NBITS-1:0];
      if ((mask_q == '0) || (entry_in != tag_q)) begin
        tag_q  <= entry_in;
        mask_q <= lane_bit;
      end else begin
        mask_q <= mask_q | lane_bit;
      end
    end
  end

  encap_mem_wide_ram #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS)) u_pio_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (tag_q),
    .wdata (stage_q[WIDTH-1:0]),
    .re    (rd_acc),
    .raddr (entry_in),
    .rdata (pio_q)
  );

  for (genvar i = 0; i < NUM_APP; i++) begin : g_app
    encap_mem_wide_ram #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS)) u_app_ram (
      .clk   (clk),
      .we    (commit),
      .waddr (tag_q),
      .wdata (stage_q[WIDTH-1:0]),
      .re    (app_rd[i]),
      .raddr (app_raddr[i*DEPTH_NBITS +: DEPTH_NBITS]),
      .rdata (app_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1_q   <= '0;
      app_ack   <= '0;
      app_rdata <= '0;
    end else begin
      rd_d1_q <= app_rd;
      app_ack <= rd_d1_q;
      for (int unsigned i = 0; i < NUM_APP; i++)
        if (rd_d1_q[i]) app_rdata[i*WIDTH +: WIDTH] <= app_q[i];
    end
  end

endmodule
